// File: rtl/sha512_padder_if.sv
// Word-in / block-out handshake bundle for the SHA-512 message padder.
// The padder connects through the slave modport; the word source and block sink use master.
interface sha512_padder_if;
  logic          clear_i;
  logic [63:0]   data_i;
  logic          valid_i;
  logic          last_i;
  logic [3:0]    last_bytes_i;
  logic          ready_o;
  logic [1023:0] block_o;
  logic          block_valid_o;
  logic          block_ready_i;
  logic          block_first_o;
  logic          block_last_o;
  logic          err_o;

  modport slave (
    input  clear_i, data_i, valid_i, last_i, last_bytes_i, block_ready_i,
    output ready_o, block_o, block_valid_o, block_first_o, block_last_o, err_o
  );

  modport master (
    output clear_i, data_i, valid_i, last_i, last_bytes_i, block_ready_i,
    input  ready_o, block_o, block_valid_o, block_first_o, block_last_o, err_o
  );
endinterface

// File: rtl/sha512_padder.sv
// SHA-512 message padder: 64-bit big-endian words in, padded 1024-bit blocks out.
// Define SHA512_PAD_ERR_EN to build the sticky last_bytes_i>8 protocol-error flag.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_FILL      | collecting words into the block buffer
// S_EMIT      | presenting the filled block, held until accepted
// S_EMIT_XTRA | presenting the extra length-only block of a message
module sha512_padder #(
  parameter int DataWidth  = 64,
  parameter int BlockWidth = 1024,
  parameter int LenWidth   = 128
) (
  input logic            clk_i,
  input logic            rst_ni,
  sha512_padder_if.slave bus
);

  localparam int Words = BlockWidth / DataWidth;
  localparam logic [DataWidth-1:0] Marker = {8'h80, {(DataWidth-8){1'b0}}};

  typedef enum logic [1:0] {
    S_FILL,
    S_EMIT,
    S_EMIT_XTRA
  } state_e;

  state_e                r_state, w_state_nxt;
  logic [DataWidth-1:0]  r_buf     [Words];
  logic [DataWidth-1:0]  w_buf_nxt [Words];
  logic [3:0]            r_w, w_w_nxt;
  logic [LenWidth-1:0]   r_bits, w_bits_nxt, w_bits_add;
  logic                  r_first_pend, w_first_pend_nxt;
  logic                  r_last, w_last_nxt;
  logic                  r_xtra, w_xtra_nxt;
  logic                  r_p16, w_p16_nxt;

  logic [3:0]            w_k;
  logic [6:0]            w_inc;
  logic [4:0]            w_p;
  logic [DataWidth-1:0]  w_tail;
  logic [127:0]          w_len_new;
  logic [127:0]          w_len_reg;
  logic [BlockWidth-1:0] w_block;

  // Byte counts above 8 are clamped so the word is treated as full.
  assign w_k        = (bus.last_bytes_i > 4'd8) ? 4'd8 : bus.last_bytes_i;
  assign w_inc      = bus.last_i ? {w_k, 3'b000} : 7'd64;
  assign w_bits_add = r_bits + LenWidth'(w_inc);
  assign w_p        = {1'b0, r_w} + {4'b0000, (w_k == 4'd8)};
  assign w_len_new  = 128'(w_bits_add);
  assign w_len_reg  = 128'(r_bits);

  always_comb begin
    w_tail = '0;
    for (int b = 0; b < DataWidth / 8; b++) begin
      if (4'(b) < w_k) begin
        w_tail[DataWidth-1-8*b -: 8] = bus.data_i[DataWidth-1-8*b -: 8];
      end else if (4'(b) == w_k) begin
        w_tail[DataWidth-1-8*b -: 8] = 8'h80;
      end
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_buf_nxt        = r_buf;
    w_w_nxt          = r_w;
    w_bits_nxt       = r_bits;
    w_first_pend_nxt = r_first_pend;
    w_last_nxt       = r_last;
    w_xtra_nxt       = r_xtra;
    w_p16_nxt        = r_p16;

    case (r_state)
      S_FILL: begin
        if (bus.valid_i) begin
          w_bits_nxt = w_bits_add;
          if (!bus.last_i) begin
            w_buf_nxt[r_w] = bus.data_i;
            w_w_nxt        = r_w + 4'd1;
            if (r_w == 4'd15) begin
              w_state_nxt = S_EMIT;
              w_last_nxt  = 1'b0;
              w_xtra_nxt  = 1'b0;
            end
          end else begin
            for (int i = 0; i < Words; i++) begin
              if (5'(i) > w_p) w_buf_nxt[i] = '0;
            end
            w_buf_nxt[r_w] = w_tail;
            if ((w_k == 4'd8) && (r_w != 4'd15)) w_buf_nxt[r_w + 4'd1] = Marker;
            // Length fits behind the marker only if two whole slots remain.
            if (w_p <= 5'd13) begin
              w_buf_nxt[Words-2] = w_len_new[127:64];
              w_buf_nxt[Words-1] = w_len_new[63:0];
              w_last_nxt         = 1'b1;
              w_xtra_nxt         = 1'b0;
            end else begin
              w_last_nxt = 1'b0;
              w_xtra_nxt = 1'b1;
              w_p16_nxt  = (w_p == 5'd16);
            end
            w_state_nxt = S_EMIT;
          end
        end
      end

      S_EMIT: begin
        if (bus.block_ready_i) begin
          for (int i = 0; i < Words; i++) w_buf_nxt[i] = '0;
          w_w_nxt = 4'd0;
          if (r_xtra) begin
            w_first_pend_nxt   = 1'b0;
            w_buf_nxt[0]       = r_p16 ? Marker : '0;
            w_buf_nxt[Words-2] = w_len_reg[127:64];
            w_buf_nxt[Words-1] = w_len_reg[63:0];
            w_state_nxt        = S_EMIT_XTRA;
          end else begin
            w_first_pend_nxt = r_last;
            if (r_last) w_bits_nxt = '0;
            w_state_nxt = S_FILL;
          end
        end
      end

      S_EMIT_XTRA: begin
        if (bus.block_ready_i) begin
          for (int i = 0; i < Words; i++) w_buf_nxt[i] = '0;
          w_w_nxt          = 4'd0;
          w_bits_nxt       = '0;
          w_first_pend_nxt = 1'b1;
          w_xtra_nxt       = 1'b0;
          w_p16_nxt        = 1'b0;
          w_state_nxt      = S_FILL;
        end
      end

      default: w_state_nxt = S_FILL;
    endcase

    if (bus.clear_i) begin
      for (int i = 0; i < Words; i++) w_buf_nxt[i] = '0;
      w_state_nxt      = S_FILL;
      w_w_nxt          = 4'd0;
      w_bits_nxt       = '0;
      w_first_pend_nxt = 1'b1;
      w_last_nxt       = 1'b0;
      w_xtra_nxt       = 1'b0;
      w_p16_nxt        = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= S_FILL;
      for (int i = 0; i < Words; i++) r_buf[i] <= '0;
      r_w          <= 4'd0;
      r_bits       <= '0;
      r_first_pend <= 1'b1;
      r_last       <= 1'b0;
      r_xtra       <= 1'b0;
      r_p16        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_buf        <= w_buf_nxt;
      r_w          <= w_w_nxt;
      r_bits       <= w_bits_nxt;
      r_first_pend <= w_first_pend_nxt;
      r_last       <= w_last_nxt;
      r_xtra       <= w_xtra_nxt;
      r_p16        <= w_p16_nxt;
    end
  end

  always_comb begin
    w_block = '0;
    for (int i = 0; i < Words; i++) begin
      w_block[BlockWidth-1-DataWidth*i -: DataWidth] = r_buf[i];
    end
  end

  assign bus.block_o       = w_block;
  assign bus.ready_o       = (r_state == S_FILL);
  assign bus.block_valid_o = (r_state != S_FILL);
  assign bus.block_first_o = (r_state == S_EMIT) && r_first_pend;
  assign bus.block_last_o  = (r_state == S_EMIT_XTRA) || ((r_state == S_EMIT) && r_last);

`ifdef SHA512_PAD_ERR_EN
  logic r_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else if (bus.clear_i) begin
      r_err <= 1'b0;
    end else if ((r_state == S_FILL) && bus.valid_i && bus.last_i &&
                 (bus.last_bytes_i > 4'd8)) begin
      r_err <= 1'b1;
    end
  end

  assign bus.err_o = r_err;
`else
  assign bus.err_o = 1'b0;
`endif

endmodule

// File: tb/tb_sha512_padder.sv
// Self-checking bench for sha512_padder: hand-derived vector table, corner sequences,
// and random messages checked against a byte-level FIPS 180-4 padding model.
module tb_sha512_padder;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  sha512_padder_if bus ();

  sha512_padder #(
    .DataWidth (64),
    .BlockWidth(1024),
    .LenWidth  (128)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  typedef struct packed {
    logic [1023:0] blk;
    logic          first;
    logic          last;
  } blk_t;

  typedef struct {
    int          nwords;
    int          k;
    int          nblk;
    logic [63:0] len;
    int          mblk;
    int          mword;
    logic [63:0] mval;
  } vec_t;

  blk_t exp_q[$];
  blk_t rx_q[$];
  vec_t vecs[8];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] word_of(input logic [1023:0] b, input int i);
    return b[1023-64*i -: 64];
  endfunction

  task automatic chk_blk(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
    int bad_w;
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      bad_w = 0;
      for (int i = 15; i >= 0; i--) if (word_of(act, i) !== word_of(exp, i)) bad_w = i;
      $display("FAIL %s: word %0d got %h want %h", nm, bad_w,
               word_of(act, bad_w), word_of(exp, bad_w));
    end
  endtask

  // Reference: flatten to bytes, append 0x80, zero-fill to 112 mod 128, append 128-bit length.
  task automatic build_expected(input logic [63:0] words[$], input int k);
    byte unsigned m[$];
    logic [127:0] bitlen;
    logic [63:0]  wd;
    int           kk, nb, nblk;
    blk_t         e;
    kk = (k > 8) ? 8 : k;
    exp_q.delete();
    for (int i = 0; i < words.size(); i++) begin
      wd = words[i];
      nb = (i == words.size() - 1) ? kk : 8;
      for (int b = 0; b < nb; b++) m.push_back(wd[63-8*b -: 8]);
    end
    bitlen = 128'(m.size()) * 128'd8;
    m.push_back(8'h80);
    while ((m.size() % 128) != 112) m.push_back(8'h00);
    for (int j = 15; j >= 0; j--) m.push_back(bitlen[8*j +: 8]);
    nblk = m.size() / 128;
    for (int bi = 0; bi < nblk; bi++) begin
      e.blk = '0;
      for (int j = 0; j < 128; j++) e.blk[1023-8*j -: 8] = m[bi*128+j];
      e.first = (bi == 0);
      e.last  = (bi == nblk - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_words(input logic [63:0] words[$], input int kdrv,
                             input bit with_last, input int gap_pct);
    int cyc;
    for (int i = 0; i < words.size(); i++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        bus.valid_i = 1'b0;
        bus.data_i  = {$urandom, $urandom};
        @(negedge clk_i);
      end
      bus.valid_i      = 1'b1;
      bus.data_i       = words[i];
      bus.last_i       = with_last && (i == words.size() - 1);
      bus.last_bytes_i = bus.last_i ? 4'(kdrv) : 4'($urandom_range(15));
      cyc = 0;
      while (!bus.ready_o && cyc < 5000) begin
        @(negedge clk_i);
        cyc++;
      end
      if (cyc >= 5000) begin
        chk1("drv_ready_timeout", 1'b0, 1'b1);
        break;
      end
      @(negedge clk_i);
    end
    bus.valid_i = 1'b0;
    bus.last_i  = 1'b0;
  endtask

  task automatic collect(input int nexp, input int bp_pct);
    int   got = 0;
    int   cyc = 0;
    blk_t e;
    while (got < nexp && cyc < 20000) begin
      bus.block_ready_i = (int'($urandom_range(99)) >= bp_pct);
      if (bus.block_valid_o && bus.block_ready_i) begin
        e.blk   = bus.block_o;
        e.first = bus.block_first_o;
        e.last  = bus.block_last_o;
        rx_q.push_back(e);
        got++;
      end
      @(negedge clk_i);
      cyc++;
    end
    bus.block_ready_i = 1'b0;
    if (got < nexp) chk1("collect_timeout", 1'b0, 1'b1);
  endtask

  task automatic run_msg(input logic [63:0] words[$], input int kdrv,
                         input int gap, input int bp, input string tag);
    blk_t a, e;
    int   n;
    build_expected(words, kdrv);
    rx_q.delete();
    fork
      drive_words(words, kdrv, 1'b1, gap);
      collect(exp_q.size(), bp);
    join
    chk64({tag, "_nblk"}, 64'(rx_q.size()), 64'(exp_q.size()));
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      a = rx_q[i];
      e = exp_q[i];
      chk_blk($sformatf("%s_blk%0d", tag, i), a.blk, e.blk);
      chk1($sformatf("%s_first%0d", tag, i), a.first, e.first);
      chk1($sformatf("%s_last%0d", tag, i), a.last, e.last);
    end
    chk1({tag, "_idle_ready"}, bus.ready_o, 1'b1);
    chk1({tag, "_idle_valid"}, bus.block_valid_o, 1'b0);
  endtask

  task automatic pulse_clear();
    bus.clear_i = 1'b1;
    @(negedge clk_i);
    bus.clear_i = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0]   wq[$];
    logic [1023:0] abc_blk, snap, lb, mb;
    blk_t          e;
    int            n, k;

    abc_blk = {64'h6162_6380_0000_0000, 896'b0, 64'h18};

    vecs[0] = '{1,  3, 1, 64'h18,  0, 0,  64'h1122_3380_0000_0000};
    vecs[1] = '{1,  0, 1, 64'h0,   0, 0,  64'h8000_0000_0000_0000};
    vecs[2] = '{14, 8, 2, 64'h380, 0, 14, 64'h8000_0000_0000_0000};
    vecs[3] = '{16, 8, 2, 64'h400, 1, 0,  64'h8000_0000_0000_0000};
    vecs[4] = '{14, 7, 1, 64'h378, 0, 13, 64'h1122_3344_5566_7780};
    vecs[5] = '{15, 0, 2, 64'h380, 0, 14, 64'h8000_0000_0000_0000};
    vecs[6] = '{17, 1, 2, 64'h408, 1, 0,  64'h1180_0000_0000_0000};
    vecs[7] = '{16, 4, 2, 64'h3E0, 0, 15, 64'h1122_3344_8000_0000};

    bus.clear_i       = 1'b0;
    bus.valid_i       = 1'b0;
    bus.data_i        = '0;
    bus.last_i        = 1'b0;
    bus.last_bytes_i  = '0;
    bus.block_ready_i = 1'b0;
    rst_ni            = 1'b0;
    repeat (3) @(negedge clk_i);
    chk1("rst_ready", bus.ready_o, 1'b1);
    chk1("rst_valid", bus.block_valid_o, 1'b0);
    chk1("rst_first", bus.block_first_o, 1'b0);
    chk1("rst_last", bus.block_last_o, 1'b0);
    chk1("rst_err", bus.err_o, 1'b0);
    chk_blk("rst_block", bus.block_o, '0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    for (int v = 0; v < 8; v++) begin
      wq.delete();
      for (int i = 0; i < vecs[v].nwords; i++) wq.push_back(64'h1122_3344_5566_7788);
      run_msg(wq, vecs[v].k, 20, 30, $sformatf("vec%0d", v));
      chk64($sformatf("vec%0d_nblk_tab", v), 64'(rx_q.size()), 64'(vecs[v].nblk));
      if (rx_q.size() == vecs[v].nblk) begin
        e  = rx_q[rx_q.size()-1];
        lb = e.blk;
        e  = rx_q[vecs[v].mblk];
        mb = e.blk;
        chk64($sformatf("vec%0d_len", v), word_of(lb, 15), vecs[v].len);
        chk64($sformatf("vec%0d_lenhi", v), word_of(lb, 14), 64'h0);
        chk64($sformatf("vec%0d_marker", v), word_of(mb, vecs[v].mword), vecs[v].mval);
        e = rx_q[0];
        chk1($sformatf("vec%0d_first_tab", v), e.first, 1'b1);
      end
    end

    // "abc" with five cycles of downstream backpressure
    wq.delete();
    wq.push_back(64'h6162_6300_0000_0000);
    bus.block_ready_i = 1'b0;
    drive_words(wq, 3, 1'b1, 0);
    chk1("bp_latency_valid", bus.block_valid_o, 1'b1);
    snap = bus.block_o;
    chk_blk("bp_abc_block", snap, abc_blk);
    chk1("bp_abc_first", bus.block_first_o, 1'b1);
    chk1("bp_abc_last", bus.block_last_o, 1'b1);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk_i);
      chk1($sformatf("bp_hold_valid%0d", c), bus.block_valid_o, 1'b1);
      chk1($sformatf("bp_hold_ready%0d", c), bus.ready_o, 1'b0);
      chk_blk($sformatf("bp_hold_block%0d", c), bus.block_o, snap);
    end
    @(negedge clk_i);
    bus.block_ready_i = 1'b1;
    chk1("bp_c6_valid", bus.block_valid_o, 1'b1);
    @(negedge clk_i);
    bus.block_ready_i = 1'b0;
    chk1("bp_after_ready", bus.ready_o, 1'b1);
    chk1("bp_after_valid", bus.block_valid_o, 1'b0);

    // clear_i after seven words; clear wins over a simultaneous last word
    wq.delete();
    for (int i = 0; i < 7; i++) wq.push_back({$urandom, $urandom});
    drive_words(wq, 8, 1'b0, 10);
    bus.valid_i      = 1'b1;
    bus.data_i       = 64'hDEAD_BEEF_0BAD_F00D;
    bus.last_i       = 1'b1;
    bus.last_bytes_i = 4'd8;
    pulse_clear();
    bus.valid_i = 1'b0;
    bus.last_i  = 1'b0;
    chk1("clr_ready", bus.ready_o, 1'b1);
    chk1("clr_valid", bus.block_valid_o, 1'b0);
    wq.delete();
    wq.push_back(64'h6162_6300_0000_0000);
    run_msg(wq, 3, 0, 0, "clr_abc");
    if (rx_q.size() == 1) begin
      e = rx_q[0];
      chk_blk("clr_abc_const", e.blk, abc_blk);
      chk1("clr_abc_first", e.first, 1'b1);
    end

    // last_bytes_i above 8 pads as a full word
    wq.delete();
    wq.push_back(64'h0102_0304_0506_0708);
    wq.push_back(64'h1112_1314_1516_1718);
    run_msg(wq, 12, 0, 0, "k12");
`ifdef SHA512_PAD_ERR_EN
    chk1("err_set", bus.err_o, 1'b1);
    wq.delete();
    wq.push_back(64'h6162_6300_0000_0000);
    run_msg(wq, 3, 0, 0, "err_sticky_abc");
    chk1("err_sticky", bus.err_o, 1'b1);
    pulse_clear();
    chk1("err_cleared", bus.err_o, 1'b0);
`else
    chk1("err_tied", bus.err_o, 1'b0);
`endif

    // async reset while a block and its extra block are pending
    wq.delete();
    for (int i = 0; i < 16; i++) wq.push_back({$urandom, $urandom});
    bus.block_ready_i = 1'b0;
    drive_words(wq, 8, 1'b1, 0);
    chk1("mid_emit_valid", bus.block_valid_o, 1'b1);
    rst_ni = 1'b0;
    #1;
    chk1("mid_rst_valid", bus.block_valid_o, 1'b0);
    chk1("mid_rst_ready", bus.ready_o, 1'b1);
    chk_blk("mid_rst_block", bus.block_o, '0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    wq.delete();
    wq.push_back(64'h6162_6300_0000_0000);
    run_msg(wq, 3, 0, 0, "post_rst_abc");

    for (int r = 0; r < 25; r++) begin
      n = $urandom_range(1, 40);
      k = $urandom_range(0, 10);
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back({$urandom, $urandom});
      run_msg(wq, k, 30, 40, $sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sha512_padder.md
Name: sha512_padder

Overview:
- Message-padding front end for the SHA-512 core.
- Accepts a 64-bit big-endian word stream with a last-word byte count.
- Appends the 0x80 marker, zero fill and the 128-bit bit-length field per FIPS 180-4.
- Emits complete 1024-bit blocks over a valid/ready handshake, with first/last flags that drive the core's hash-reset and enable controls.

Parameters:
- DataWidth, 64, input word width; fixed at 64.
- BlockWidth, 1024, output block width; fixed at 1024.
- LenWidth, 128, width of the internal bit-length counter (64..128); zero-extended into the 128-bit length field.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous abort; discards the partial message
- data_i  in  64  message word; byte 0 at [63:56]
- valid_i  in  1  data_i valid
- last_i  in  1  final word of message
- last_bytes_i  in  4  valid bytes in the last word (0..8); ignored when last_i=0
- ready_o  out  1  padder accepts a word
- block_o  out  1024  padded block; word 0 at [1023:960]
- block_valid_o  out  1  block_o valid
- block_ready_i  in  1  downstream accepts the block
- block_first_o  out  1  block is the first of its message
- block_last_o  out  1  block is the final one (carries the length)
- err_o  out  1  sticky protocol error (see Optional Feature)

Behaviour:
- States: S_FILL, S_EMIT, S_EMIT_XTRA.
- Reset (async) and clear_i:
  - state=S_FILL, word count w=0, bit count=0, buffer=0, first_pend=1.
  - Outputs: ready_o=1, block_valid_o=0, block_first_o=0, block_last_o=0, block_o=0, err_o=0.
  - clear_i has priority over all other events in its cycle.
- S_FILL:
  - ready_o=1, block_valid_o=0. A word transfers on valid_i&&ready_o.
  - Non-last word: written to slot w; bit count += 64; w++. If w was 15, go to S_EMIT with last=0.
  - Last word with k=last_bytes_i:
    - Slot w gets bytes 0..k-1, then byte k=0x80 if k<8; remaining bytes are zero.
    - If k=8, the marker goes into byte 0 of slot w+1 (p=w+1); otherwise p=w.
    - Bit count += 8k. Slots after p are zeroed.
    - p<=13: slots 14..15 = 128-bit length; go to S_EMIT with last=1.
    - p in 14..15: go to S_EMIT with last=0 and the extra-block flag set.
    - p=16 (w=15, k=8): go to S_EMIT with last=0 and the extra-block flag set; the extra block starts 0x80.
- S_EMIT:
  - ready_o=0, block_valid_o=1. block_o and the flags are held stable until accepted.
  - block_first_o=first_pend.
  - Valid-to-accept latency: block_valid_o rises the cycle after the completing word transfers.
  - On acceptance:
    - first_pend is cleared, or set to 1 if last.
    - If the extra-block flag is set: load the extra block (word 0 = 0x8000_0000_0000_0000 if p=16, else 0; words 1..13 = 0; words 14..15 = length) and go to S_EMIT_XTRA.
    - Otherwise: clear the buffer, w=0, go to S_FILL; if last, also clear the bit count.
- S_EMIT_XTRA:
  - block_valid_o=1, block_last_o=1, block_first_o=0.
  - On acceptance: clear the buffer, w=0, bit count=0, first_pend=1, go to S_FILL.
- Length field:
  - 128-bit big-endian; bits [LenWidth-1:0] come from the counter, upper bits are 0.
  - Counter wraps modulo 2^LenWidth.
- Single-word blocks:
  - last_bytes_i=0 with last_i=1 is legal; it gives an empty tail, and an empty message yields word 0 = 0x80...
- Reset mid-operation: async; the partial block and any pending extra block are lost.

Optional Feature:
- Macro: SHA512_PAD_ERR_EN.
- Defined:
  - A transfer with last_i=1 and last_bytes_i>8 sets err_o (sticky until clear_i or reset).
  - A valid_i pulse while ready_o=0 is not an error.
- Undefined:
  - err_o is tied to 0 and no check logic is built.
- Both builds: last_bytes_i>8 is clamped to 8.

Test Plan:
- "abc": one word 0x6162_6300_0000_0000, last=1, k=3 → one block; word0=0x6162_6380_0000_0000, words1..14=0, word15=0x18, first=1, last=1.
- Empty message: last=1, k=0 → word0=0x8000_0000_0000_0000, all other words 0, first=last=1.
- 14 full words, the 14th with last=1, k=8 → block1 holds data plus word14=0x80..., word15=0, first=1, last=0; block2 words0..14=0, word15=0x380, first=0, last=1.
- 16 full words, the 16th with last=1, k=8 → block1 all data, last=0; block2 word0=0x80..., word15=0x400, last=1; then the next message's first block has first=1.
- Backpressure: block_ready_i held low 5 cycles in S_EMIT → block_valid_o stays 1, block_o unchanged, ready_o=0; acceptance on cycle 6, ready_o=1 the next cycle.
- clear_i after 7 words, then "abc" → a single correct "abc" block (word15=0x18), first=1. With SHA512_PAD_ERR_EN, last=1 and k=12 → err_o=1 and the block is padded as k=8.
